// File: rtl/control_turno_timeout.sv
// control_turno_timeout
// Per-turn sequencer for the memory-card game. Counts down the current
// player's turn time. When it expires, fires the random-card reveal
// datapath and waits for its done. It then ends the turn and hands it to
// the other player.
//
// Parameters:
//   CLK_HZ        clock cycles per one-second tick (>=2)
//   TURN_SECONDS  seconds per turn (1..31)
//   WD_CYCLES     reveal-done watchdog limit in cycles (watchdog build only)
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_turn_start     pulse, arms a new turn (accepted only when idle)
//   i_player_done    pulse, player ended the turn manually
//   i_reveal_done    done from the reveal datapath (level or pulse)
//   o_reveal_start   one-cycle start pulse to the reveal datapath
//   o_turn_over      one-cycle pulse, turn finished
//   o_timed_out      high from timeout until the next accepted turn_start
//   o_seconds_left   remaining seconds of the current turn
//   o_player         current player (0/1)
//   o_busy           high whenever not idle
//   o_wd_error       sticky watchdog flag
//
// Build option: define TURN_WATCHDOG_EN to bound the wait for reveal_done
// to WD_CYCLES cycles. When it is undefined, the wait is unbounded and
// o_wd_error is tied to 0.
module control_turno_timeout #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TURN_SECONDS = 15,
  parameter int unsigned WD_CYCLES    = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_turn_start,
  input  logic       i_player_done,
  input  logic       i_reveal_done,
  output logic       o_reveal_start,
  output logic       o_turn_over,
  output logic       o_timed_out,
  output logic [4:0] o_seconds_left,
  output logic       o_player,
  output logic       o_busy,
  output logic       o_wd_error
);

  localparam int unsigned    PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [4:0]     SECS_INIT = 5'(TURN_SECONDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_REVEAL = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [4:0]    r_secs;
  logic          r_timed_out;
  logic          r_player;
  logic          w_tick;
  logic          w_wait_exit;

  assign w_tick = (r_pre == PRE_LAST);

`ifdef TURN_WATCHDOG_EN
  localparam int unsigned   WW      = $clog2(WD_CYCLES) + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);

  logic [WW-1:0] r_wd_cnt;
  logic          r_wd_error;
  logic          w_wd_fire;

  // Fires on the last allowed WAIT_DONE cycle that still has no done.
  assign w_wd_fire   = (r_state == S_WAIT) && !i_reveal_done && (r_wd_cnt == WD_LAST);
  assign w_wait_exit = i_reveal_done | w_wd_fire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd_cnt   <= '0;
      r_wd_error <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_fire) r_wd_error <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign o_wd_error = r_wd_error;
`else
  // WD_CYCLES only matters in the watchdog build.
  logic w_unused_wd;
  assign w_unused_wd = |WD_CYCLES;
  assign w_wait_exit = i_reveal_done;
  assign o_wd_error  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_turn_start) w_state_nxt = S_RUN;
      // Manual finish beats an expiring tick in the same cycle.
      S_RUN:    if (i_player_done)                w_state_nxt = S_END;
                else if (w_tick && r_secs == 5'd1) w_state_nxt = S_REVEAL;
      S_REVEAL: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_wait_exit) w_state_nxt = S_END;
      S_END:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_secs      <= SECS_INIT;
      r_timed_out <= 1'b0;
      r_player    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (i_turn_start) begin
          r_pre       <= '0;
          r_secs      <= SECS_INIT;
          r_timed_out <= 1'b0;
        end
        // player_done freezes the countdown where it stands.
        S_RUN: if (!i_player_done) begin
          r_pre <= w_tick ? '0 : r_pre + 1'b1;
          if (w_tick && r_secs != 5'd0) begin
            r_secs <= r_secs - 5'd1;
            if (r_secs == 5'd1) r_timed_out <= 1'b1;
          end
        end
        S_END: r_player <= ~r_player;
        default: ;
      endcase
    end
  end

  assign o_reveal_start = (r_state == S_REVEAL);
  assign o_turn_over    = (r_state == S_END);
  assign o_busy         = (r_state != S_IDLE);
  assign o_timed_out    = r_timed_out;
  assign o_seconds_left = r_secs;
  assign o_player       = r_player;

endmodule

// File: tb/tb_control_turno_timeout.sv
module tb_control_turno_timeout;
  localparam int HZ = 4;
  localparam int TS = 3;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ts = 1'b0, pd = 1'b0, rd = 1'b0;
  logic       o_reveal_start, o_turn_over, o_timed_out, o_player, o_busy, o_wd_error;
  logic [4:0] o_seconds_left;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  control_turno_timeout #(.CLK_HZ(HZ), .TURN_SECONDS(TS), .WD_CYCLES(WD)) dut (
    .i_clk(clk), .i_rst(rst), .i_turn_start(ts), .i_player_done(pd), .i_reveal_done(rd),
    .o_reveal_start(o_reveal_start), .o_turn_over(o_turn_over), .o_timed_out(o_timed_out),
    .o_seconds_left(o_seconds_left), .o_player(o_player), .o_busy(o_busy), .o_wd_error(o_wd_error)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a turn is a phase plus a count of cycles spent running;
  // the seconds display is derived arithmetically from that count.
  localparam int P_IDLE = 0, P_RUN = 1, P_REV = 2, P_WAIT = 3, P_END = 4;
  int m_phase = P_IDLE;
  int m_run = 0;
  int m_wait = 0;
  int m_secs = TS;
  bit m_to = 0, m_player = 0, m_wderr = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_secs = TS; m_to = 0; m_player = 0; m_wderr = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (ts) begin m_phase = P_RUN; m_run = 0; m_secs = TS; m_to = 0; end
        P_RUN: begin
          if (pd) m_phase = P_END;
          else if (m_run + 1 == TS * HZ) begin m_phase = P_REV; m_secs = 0; m_to = 1; end
          else begin m_run++; m_secs = TS - m_run / HZ; end
        end
        P_REV: begin m_phase = P_WAIT; m_wait = 0; end
        P_WAIT: begin
          if (rd) m_phase = P_END;
          else begin
            m_wait++;
`ifdef TURN_WATCHDOG_EN
            if (m_wait == WD) begin m_wderr = 1; m_phase = P_END; end
`endif
          end
        end
        default: begin m_player = !m_player; m_phase = P_IDLE; end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    chk("reveal_start", int'(o_reveal_start), int'(m_phase == P_REV));
    chk("turn_over",    int'(o_turn_over),    int'(m_phase == P_END));
    chk("busy",         int'(o_busy),         int'(m_phase != P_IDLE));
    chk("timed_out",    int'(o_timed_out),    int'(m_to));
    chk("seconds_left", int'(o_seconds_left), m_secs);
    chk("player",       int'(o_player),       int'(m_player));
    chk("wd_error",     int'(o_wd_error),     int'(m_wderr));
  end

  task automatic step(input logic t, input logic p, input logic r, input logic x);
    @(negedge clk);
    ts = t; pd = p; rd = r; rst = x;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reveal(output int n);
    n = 1;
    while (!o_reveal_start && n < 40) begin step(0, 0, 0, 0); n++; end
    chk("reveal_seen", int'(o_reveal_start), 1);
  endtask

  int n;
  int saw_to;

  initial begin
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_secs", int'(o_seconds_left), 3);
    chk("rst_player", int'(o_player), 0);
    chk("rst_busy", int'(o_busy), 0);

    // Timeout: 3 seconds of 4 cycles, reveal appears 13 edges after start.
    step(1, 0, 0, 0);
    chk("start_busy", int'(o_busy), 1);
    wait_reveal(n);
    chk("timeout_latency", n, 13);
    chk("timeout_flag", int'(o_timed_out), 1);
    chk("timeout_secs", int'(o_seconds_left), 0);
    step(0, 0, 1, 0);                 // leaves REVEAL with done already high
    step(0, 0, 1, 0);                 // first WAIT_DONE cycle accepts it
    chk("done_turn_over", int'(o_turn_over), 1);
    step(0, 0, 0, 0);
    chk("timeout_player", int'(o_player), 1);
    chk("timeout_idle", int'(o_busy), 0);

    // Manual finish at seconds_left=2.
    step(1, 0, 0, 0);
    n = 0;
    while (o_seconds_left != 5'd2 && n < 20) begin step(0, 0, 0, 0); n++; end
    chk("manual_secs2", int'(o_seconds_left), 2);
    step(0, 1, 0, 0);
    chk("manual_turn_over", int'(o_turn_over), 1);
    chk("manual_no_timeout", int'(o_timed_out), 0);
    chk("manual_secs_hold", int'(o_seconds_left), 2);
    step(0, 0, 0, 0);
    chk("manual_player", int'(o_player), 0);

    // player_done coincides with the expiring tick (13th running edge).
    step(1, 0, 0, 0);
    repeat (11) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("simul_turn_over", int'(o_turn_over), 1);
    chk("simul_no_reveal", int'(o_reveal_start), 0);
    chk("simul_no_timeout", int'(o_timed_out), 0);
    chk("simul_secs", int'(o_seconds_left), 1);
    step(0, 0, 0, 0);
    chk("simul_player", int'(o_player), 1);

    // Ignored inputs: turn_start mid-run, player_done while waiting.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("ign_secs", int'(o_seconds_left), 3);
    wait_reveal(n);
    chk("ign_latency", n, 10);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("ign_pd_busy", int'(o_busy), 1);
    chk("ign_pd_no_over", int'(o_turn_over), 0);
    step(0, 0, 1, 0);
    chk("ign_done_over", int'(o_turn_over), 1);
    step(0, 0, 0, 0);

    // Reveal datapath never answers.
    step(1, 0, 0, 0);
    wait_reveal(n);
    saw_to = 0;
    repeat (12) begin
      step(0, 0, 0, 0);
      if (o_turn_over) saw_to++;
    end
`ifdef TURN_WATCHDOG_EN
    chk("wd_error_set", int'(o_wd_error), 1);
    chk("wd_turn_over", saw_to, 1);
    chk("wd_idle", int'(o_busy), 0);
`else
    chk("nowd_error", int'(o_wd_error), 0);
    chk("nowd_no_over", saw_to, 0);
    chk("nowd_busy", int'(o_busy), 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
`endif

    // Reset mid-run.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_secs", int'(o_seconds_left), 3);
    chk("midrst_player", int'(o_player), 0);
    chk("midrst_wd", int'(o_wd_error), 0);
    step(0, 0, 0, 0);
    chk("midrst_release", int'(o_busy), 0);

    // Random traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
